// File: rtl/mmio_regbank_v2.sv
// Staged CPU register bank with atomic commit and a sequential input snapshot engine.
// Optional build macro MMIO_AUTOCOMMIT_EN: a write to a register's top byte also commits that register.
module mmio_regbank_v2 #(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int AW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [7:0]          cpu_data_in,
  output logic [7:0]          cpu_data_out,
  input  logic                rd,
  input  logic                wr,
  output logic [NREGS*DW-1:0] data_out,
  input  logic [NREGS*DW-1:0] inputs,
  output logic [NREGS-1:0]    set_strobe,
  output logic                snap_busy
);
  localparam int NB  = DW / 8;
  localparam int BB  = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int AOW = AW - 1;

  localparam logic [AOW-1:0] NREGS_A   = AOW'(NREGS);
  localparam logic [AOW-1:0] BYTE_MASK = AOW'(NB - 1);
  localparam logic [AOW-1:0] A_CTRL    = AOW'(0);
  localparam logic [AOW-1:0] A_STATUS  = AOW'(1);
  localparam logic [AOW-1:0] A_STROBE  = AOW'(2);
  localparam logic [AOW-1:0] A_WINMODE = AOW'(3);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NREGS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_COPY = 1'b1
  } state_e;

  logic [DW-1:0] stage_q [NREGS];
  logic [DW-1:0] stage_d [NREGS];
  logic [DW-1:0] live_q  [NREGS];
  logic [DW-1:0] live_d  [NREGS];
  logic [DW-1:0] snap_q  [NREGS];
  logic [DW-1:0] snap_d  [NREGS];

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             snap_busy_q, snap_busy_d;
  logic             snap_done_q, snap_done_d;
  logic             win_mode_q, win_mode_d;
  logic [7:0]       cpu_data_out_q, cpu_data_out_d;
  logic [NREGS-1:0] set_strobe_q, set_strobe_d;

  logic [AOW-1:0]   off_s, widx_s, wbyte_s;
  logic             win_sel_s, win_ok_s, ctrl_wr_s;
  logic             commit_s, start_s, status_rd_s;
  logic [NREGS-1:0] reg_hit_s;
  logic [7:0]       rdata_s;

  // Next-state logic for the banks, the CPU read port, the strobes and the snapshot FSM.
  always_comb begin
    off_s       = cpu_addr[AW-2:0];
    win_sel_s   = cpu_addr[AW-1];
    widx_s      = off_s >> BB;
    wbyte_s     = off_s & BYTE_MASK;
    win_ok_s    = win_sel_s && (widx_s < NREGS_A);
    ctrl_wr_s   = wr && !win_sel_s;
    commit_s    = ctrl_wr_s && (off_s == A_CTRL) && cpu_data_in[0];
    start_s     = ctrl_wr_s && (off_s == A_CTRL) && cpu_data_in[1];
    status_rd_s = rd && !win_sel_s && (off_s == A_STATUS);

    stage_d     = stage_q;
    live_d      = live_q;
    snap_d      = snap_q;
    state_d     = state_q;
    idx_d       = idx_q;
    snap_busy_d = snap_busy_q;
    snap_done_d = status_rd_s ? 1'b0 : snap_done_q;
    win_mode_d  = win_mode_q;
    reg_hit_s   = '0;
    rdata_s     = 8'h00;

    // Reads always see pre-edge contents, so a same-cycle write to the same byte is not visible.
    if (win_sel_s) begin
      for (int i = 0; i < NREGS; i++) begin
        for (int b = 0; b < NB; b++) begin
          rdata_s = (win_ok_s && widx_s == AOW'(i) && wbyte_s == AOW'(b))
                    ? (win_mode_q ? snap_q[i][b*8 +: 8] : stage_q[i][b*8 +: 8])
                    : rdata_s;
        end
      end
    end else begin
      case (off_s)
        A_STATUS:  rdata_s = {6'b000000, snap_done_q, snap_busy_q};
        A_WINMODE: rdata_s = {7'b0000000, win_mode_q};
        default:   rdata_s = 8'h00;
      endcase
    end
    cpu_data_out_d = rd ? rdata_s : cpu_data_out_q;

    for (int i = 0; i < NREGS; i++) begin
      reg_hit_s[i] = wr && win_ok_s && (widx_s == AOW'(i));
      for (int b = 0; b < NB; b++) begin
        stage_d[i][b*8 +: 8] = (reg_hit_s[i] && wbyte_s == AOW'(b)) ? cpu_data_in : stage_q[i][b*8 +: 8];
      end
    end

    if (commit_s) begin
      live_d = stage_q;
    end else begin
      live_d = live_q;
    end
`ifdef MMIO_AUTOCOMMIT_EN
    for (int i = 0; i < NREGS; i++) begin
      live_d[i] = (reg_hit_s[i] && wbyte_s == BYTE_MASK) ? stage_d[i] : live_d[i];
    end
`endif

    if (ctrl_wr_s && off_s == A_WINMODE) begin
      win_mode_d = cpu_data_in[0];
    end else begin
      win_mode_d = win_mode_q;
    end

    for (int i = 0; i < NREGS; i++) begin
      set_strobe_d[i] = ctrl_wr_s && (off_s == A_STROBE) && (int'(cpu_data_in) == i);
    end

    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d     = S_COPY;
          idx_d       = '0;
          snap_busy_d = 1'b1;
        end else begin
          state_d     = S_IDLE;
          snap_busy_d = 1'b0;
        end
      end
      S_COPY: begin
        for (int i = 0; i < NREGS; i++) begin
          snap_d[i] = (idx_q == IW'(i)) ? inputs[i*DW +: DW] : snap_q[i];
        end
        // The done flag is set last so it wins over a coincident STATUS read.
        if (idx_q == LAST_IDX) begin
          state_d     = S_IDLE;
          snap_busy_d = 1'b0;
          snap_done_d = 1'b1;
        end else begin
          idx_d       = idx_q + IW'(1);
          snap_busy_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        snap_busy_d = 1'b0;
      end
    endcase
  end

  // State registers; reset clears every bank and aborts a copy in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q        <= '{default: '0};
      live_q         <= '{default: '0};
      snap_q         <= '{default: '0};
      state_q        <= S_IDLE;
      idx_q          <= '0;
      snap_busy_q    <= 1'b0;
      snap_done_q    <= 1'b0;
      win_mode_q     <= 1'b0;
      cpu_data_out_q <= 8'h00;
      set_strobe_q   <= '0;
    end else begin
      stage_q        <= stage_d;
      live_q         <= live_d;
      snap_q         <= snap_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      snap_busy_q    <= snap_busy_d;
      snap_done_q    <= snap_done_d;
      win_mode_q     <= win_mode_d;
      cpu_data_out_q <= cpu_data_out_d;
      set_strobe_q   <= set_strobe_d;
    end
  end

  // Flatten the live bank onto the output bus.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      data_out[i*DW +: DW] = live_q[i];
    end
  end

  assign cpu_data_out = cpu_data_out_q;
  assign set_strobe   = set_strobe_q;
  assign snap_busy    = snap_busy_q;

endmodule

// File: doc/mmio_regbank_v2.md
Name: mmio_regbank_v2

Overview:
- Parametrised successor of the 8-bit CPU memory-mapped register interface.
- Provides NREGS output registers of DW bits each. CPU byte writes land in a staging bank and reach the live outputs only on an atomic commit, so multi-byte updates never appear half-written.
- A sequential snapshot engine copies all NREGS inputs into a capture bank, giving the CPU a coherent read of the inputs.
- Sits between the soft-CPU port bus and DDA/motion datapath blocks.

Parameters:
- NREGS, 32: number of output, input and snapshot registers (2..64).
- DW, 32: register width in bits, one of 8/16/32/64.
- AW, 8: CPU address width. Requires NREGS*(DW/8) <= 2^(AW-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  AW  CPU byte address.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  CPU read data, registered.
- rd  in  1  read strobe, sampled on rising clk.
- wr  in  1  write strobe, sampled on rising clk.
- data_out  out  NREGS*DW  live registers, flattened; reg i at [i*DW +: DW].
- inputs  in  NREGS*DW  monitored inputs, flattened the same way.
- set_strobe  out  NREGS  one-cycle pulses.
- snap_busy  out  1  snapshot engine active.

Behaviour:
- Reset: asynchronous, active-low; all state clears immediately on assertion.
  - Cleared: staging, live and snapshot banks; cpu_data_out; set_strobe; snap_busy; snap_done; win_mode; FSM state.
  - Reset mid-snapshot aborts the copy; no done flag is set.
- Address decode: BB = log2(DW/8).
  - cpu_addr[AW-1]=1 selects the window: index = cpu_addr[AW-2:BB], byte = cpu_addr[BB-1:0] (byte 0 = bits 7:0).
  - cpu_addr[AW-1]=0 selects control space at cpu_addr[AW-2:0].
- Window write: updates one staging byte only; live registers are unchanged.
- Window read: returns the staging byte when win_mode=0, the snapshot byte when win_mode=1.
- Out-of-range index or control address: reads 0, writes ignored.
- Control space:
  - 0 CTRL (write-only, reads 0):
    - bit0 = commit: live <= staging for all regs in one cycle; data_out changes on the next edge.
    - bit1 = snap_start.
    - Both bits set: both actions happen.
  - 1 STATUS (read-only): {6'b0, snap_done, snap_busy}. snap_done is sticky and clears on this read. If a set and a clear coincide, the set wins.
  - 2 STROBE (write): set_strobe[cpu_data_in] is high for exactly one cycle. Index >= NREGS produces no pulse. set_strobe is otherwise 0.
  - 3 WINMODE (read/write): bit0 = win_mode.
- Read timing:
  - cpu_data_out is updated one clk after rd is sampled and holds its value when rd=0.
  - rd and wr to the same byte in the same cycle: the read returns the old value.
- Snapshot FSM, IDLE -> COPY -> IDLE:
  - IDLE: snap_start loads idx=0, sets snap_busy=1, enters COPY.
  - COPY: each cycle snap[idx] <= inputs[idx] and idx increments. After idx=NREGS-1 is copied, go to IDLE, set snap_busy=0 and snap_done=1.
  - The copy takes exactly NREGS cycles.
  - snap_start while busy is ignored; the copy is not restarted.
  - Window reads in snapshot mode during COPY are allowed; they return the bank's current contents.
  - Commit is independent of the FSM.

Optional Feature:
- Macro: MMIO_AUTOCOMMIT_EN.
- Defined: a window write to the top byte (byte = DW/8-1) of reg i also commits reg i alone, using the staging value including that byte.
  - Live reg i changes on the next edge.
  - Other registers are untouched.
  - CTRL commit still works.
- Undefined: live registers change only on a CTRL commit.

Test Plan:
- Reset: drive reset=0 mid-traffic -> all data_out=0, cpu_data_out=0, set_strobe=0, snap_busy=0, with no clock edge needed. Release reset -> STATUS reads 0x00.
- Staged commit, DW=32: write 0x78,0x56,0x34,0x12 to reg 5 bytes 0..3 -> data_out reg 5 is still 0 (autocommit off). Write CTRL=0x01 -> reg 5 = 0x12345678 one cycle later. Window read of byte 2 returns 0x34.
- Strobe: write STROBE=7 -> set_strobe=0x00000080 for exactly 1 cycle. Write STROBE=40 with NREGS=32 -> no pulse.
- Snapshot: inputs[i]=0xA000+i, write CTRL=0x02 -> snap_busy high for exactly NREGS cycles; a second start mid-copy is ignored. Then set WINMODE=1 and read reg 3 byte 0 -> 0x03. STATUS reads 0x02, then 0x00 on the next read.
- Boundaries: write a window index >= NREGS -> no change and reads 0. A simultaneous rd/wr on the same byte returns the old value. Reset asserted at COPY cycle 4 -> snapshot bank cleared, snap_done=0.
- With MMIO_AUTOCOMMIT_EN: write bytes 0..3 of reg 2 -> data_out reg 2 updates only after the byte-3 write; other regs are unchanged.
